float_mul_pipe: RTL and testbench
=================================

Name: float_mul_pipe

Overview:
Parametrised IEEE-754-style floating-point multiplier with a 3-stage pipeline and valid/ready flow control on both sides. It is the successor to the team's fixed 3-stage multiplier and adds the following: round-to-nearest-even, special-operand handling (zero, inf, NaN), exception flags and backpressure. It sits in the float datapath beside the float adder and feeds accumulator/FIFO blocks that may stall.

Parameters:
E_BIT, 8, exponent width (≥3)
F_BIT, 23, stored fraction width (≥2)
BIAS, 2^(E_BIT-1)-1, exponent bias (derived, not overridden)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands present
in_ready  output  1  block accepts operands this cycle
mul_a  input  1+E_BIT+F_BIT  operand A {sign, exp, frac}
mul_b  input  1+E_BIT+F_BIT  operand B
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
out_p  output  1+E_BIT+F_BIT  product
flag_ovf  output  1  overflow, result forced to ±inf
flag_unf  output  1  underflow, result flushed to ±0
flag_inv  output  1  invalid, result is canonical qNaN
flag_inx  output  1  inexact (rounded, overflowed or underflowed)

Behaviour:
- Reset: rst_n is asynchronous and active-low; clk is the clock. All stage valids = 0. out_valid = 0. out_p = 0. All flags = 0. in_ready = 1 one cycle after release.
- Flow control: en = !out_valid | out_ready. in_ready = en. All stages advance only when en = 1. An input is captured when in_valid & in_ready. Each stage carries a valid bit, so bubbles propagate. Outputs hold stable while out_valid & !out_ready.
- Latency: exactly 3 enabled cycles from acceptance to out_valid. Throughput: 1 result per cycle with no stall.
- Classify (stage 0):
  - exp == 0 → zero; denormals are flushed to zero on input.
  - exp all-ones & frac == 0 → inf.
  - exp all-ones & frac != 0 → NaN.
  - Sign = sA ^ sB.
  - Significand product of {1,fA}×{1,fB} is 2F_BIT+2 bits.
  - Exponent sum eA+eB-BIAS is held signed, E_BIT+2 bits.
- Stage 1 normalise:
  - If product MSB = 1: shift right 1 and exponent+1.
  - Extract F_BIT fraction bits, guard bit G, and sticky S = OR of the remaining low bits.
- Stage 2 round (RNE): increment if G & (S | lsb).
  - On mantissa carry-out: fraction = 0, exponent+1.
  - Then check range:
    - exponent ≥ 2^E_BIT-1 → ±inf, flag_ovf = 1, flag_inx = 1.
    - exponent ≤ 0 → ±0, flag_unf = 1, flag_inx = (product nonzero).
  - Otherwise flag_inx = G | S.
- Special-case priority (decided in stage 0, carried as a 2-bit class down the pipe):
  1. Any NaN operand, or inf×0 → qNaN = {0, all-ones, 1, zeros}, flag_inv = 1, other flags 0.
  2. inf×(finite non-zero or inf) → {sign, all-ones, 0}.
  3. zero×finite → {sign, 0, 0}.
  4. Otherwise normal path.
- Flags are per-result and valid only with out_valid. They are not sticky.
- Reset mid-operation discards all in-flight results. There is no partial output.

Decomposition:
- Package float_pkg holds:
  - class encoding (NORM, ZERO, INF, NAN);
  - localparam functions for BIAS, EXP_MAX and QNAN pattern per E_BIT/F_BIT;
  - flag struct {ovf, unf, inv, inx}.
- One sub-module, float_round_rne: combinational; takes {exp, frac, G, S}; returns {exp, frac, carry}. It is reused later by the float adder.

Test Plan:
- 0x3FC00000 × 0x40000000, out_ready = 1 → out_p = 0x40400000 after 3 cycles, all flags 0.
- 0x3F800001 × 0x3F800001 → 0x3F800002, flag_inx = 1. 0x3FFFFFFF × 0x3FFFFFFF → 0x407FFFFE, flag_inx = 1 (normalisation shift plus round).
- Specials:
  - 0x7F000000 × 0x40000000 → 0x7F800000, flag_ovf = 1.
  - 0x00800000 × 0x00800000 → 0x00000000, flag_unf = 1.
  - 0x7F800000 × 0x00000000 → 0x7FC00000, flag_inv = 1.
  - 0xFF800000 × 0x40000000 → 0xFF800000.
- Backpressure: stream 8 random operand pairs, hold out_ready = 0 for cycles 4–9 → in_ready = 0 while stalled; no loss, duplication or reordering versus a reference model; out_p stable during the stall.
- Assert rst_n low mid-stream with 3 results in flight → out_valid = 0 immediately (asynchronously); after release, the first new pair emerges 3 cycles later and no old results appear.

Source files
------------

// File: rtl/float_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// float_pkg: shared operand classes, flag bundle and format helpers. Rev 1.0
// ---------------------------------------------------------------------------
package float_pkg;

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_t;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inv;
    logic inx;
  } flags_t;

  function automatic int exp_bias(input int e_bit);
    return (1 << (e_bit - 1)) - 1;
  endfunction

  function automatic int exp_max(input int e_bit);
    return (1 << e_bit) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [63:0] qnan_pattern(input int e_bit, input int f_bit);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i >= f_bit && i < f_bit + e_bit) r[i] = 1'b1;
    end
    r[f_bit-1] = 1'b1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/float_round_rne.sv
`default_nettype none
// ---------------------------------------------------------------------------
// float_round_rne: combinational round-to-nearest-even on a normalised
// fraction with guard/sticky. Rev 1.0
// ---------------------------------------------------------------------------
module float_round_rne #(
  parameter int E_BIT = 8,
  parameter int F_BIT = 23
) (
  input  logic signed [E_BIT+1:0] i_exp,
  input  logic        [F_BIT-1:0] i_frac,
  input  logic                    i_g,
  input  logic                    i_s,
  output logic signed [E_BIT+1:0] o_exp,
  output logic        [F_BIT-1:0] o_frac,
  output logic                    o_carry
);

  logic           w_inc;
  logic [F_BIT:0] w_sum;

  assign w_inc   = i_g & (i_s | i_frac[0]);
  assign w_sum   = {1'b0, i_frac} + {{F_BIT{1'b0}}, w_inc};
  assign o_carry = w_sum[F_BIT];
  assign o_frac  = w_sum[F_BIT-1:0];
  assign o_exp   = i_exp + {{(E_BIT+1){1'b0}}, o_carry};

endmodule
`default_nettype wire

// File: rtl/float_mul_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// float_mul_pipe: 3-stage floating-point multiplier (classify/multiply,
// normalise, round/pack) with RNE, special operands and valid/ready. Rev 1.0
// ---------------------------------------------------------------------------
module float_mul_pipe
  import float_pkg::*;
#(
  parameter int E_BIT = 8,
  parameter int F_BIT = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [E_BIT+F_BIT:0]   mul_a,
  input  logic [E_BIT+F_BIT:0]   mul_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [E_BIT+F_BIT:0]   out_p,
  output logic                   flag_ovf,
  output logic                   flag_unf,
  output logic                   flag_inv,
  output logic                   flag_inx
);

  localparam int W  = 1 + E_BIT + F_BIT;
  localparam int PW = 2 * F_BIT + 2;
  localparam int EW = E_BIT + 2;
  localparam logic signed [EW-1:0] c_BIAS      = EW'(exp_bias(E_BIT));
  localparam logic signed [EW-1:0] c_EXP_MAX   = EW'(exp_max(E_BIT));
  localparam logic signed [EW-1:0] c_EXP_ZERO  = '0;
  localparam logic [63:0]          c_QNAN_WIDE = qnan_pattern(E_BIT, F_BIT);
  localparam logic [W-1:0]         c_QNAN      = c_QNAN_WIDE[W-1:0];

  logic w_en;
  assign w_en     = !out_valid | out_ready;
  assign in_ready = w_en;

  // ---- stage 0: classify and multiply ----
  logic [E_BIT-1:0] w_ea, w_eb;
  logic [F_BIT-1:0] w_fa, w_fb;
  logic             w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
  cls_t             w_cls;
  logic signed [EW-1:0] w_exp0;
  logic [PW-1:0]    w_prod;

  assign w_ea     = mul_a[W-2 -: E_BIT];
  assign w_eb     = mul_b[W-2 -: E_BIT];
  assign w_fa     = mul_a[F_BIT-1:0];
  assign w_fb     = mul_b[F_BIT-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) && (w_fa == '0);
  assign w_b_inf  = (&w_eb) && (w_fb == '0);
  assign w_a_nan  = (&w_ea) && (w_fa != '0);
  assign w_b_nan  = (&w_eb) && (w_fb != '0);
  assign w_exp0   = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - c_BIAS;
  assign w_prod   = {{(F_BIT+1){1'b0}}, 1'b1, w_fa} * {{(F_BIT+1){1'b0}}, 1'b1, w_fb};

  always_comb begin
    w_cls = CLS_NORM;
    if (w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero)) w_cls = CLS_NAN;
    else if (w_a_inf | w_b_inf)                                          w_cls = CLS_INF;
    else if (w_a_zero | w_b_zero)                                        w_cls = CLS_ZERO;
  end

  logic                 r_v0, r_sign0;
  cls_t                 r_cls0;
  logic signed [EW-1:0] r_exp0;
  logic [PW-1:0]        r_prod0;

  // ---- stage 1: normalise into fraction, guard and sticky ----
  logic                 w_msb;
  logic signed [EW-1:0] w_exp1;
  logic [F_BIT-1:0]     w_frac1;
  logic                 w_g1, w_s1;

  assign w_msb   = r_prod0[PW-1];
  assign w_exp1  = w_msb ? r_exp0 + EW'(1) : r_exp0;
  assign w_frac1 = w_msb ? r_prod0[PW-2 -: F_BIT] : r_prod0[PW-3 -: F_BIT];
  assign w_g1    = w_msb ? r_prod0[F_BIT] : r_prod0[F_BIT-1];
  assign w_s1    = w_msb ? |r_prod0[F_BIT-1:0] : |r_prod0[F_BIT-2:0];

  logic                 r_v1, r_sign1, r_g1, r_s1;
  cls_t                 r_cls1;
  logic signed [EW-1:0] r_exp1;
  logic [F_BIT-1:0]     r_frac1;

  // ---- stage 2: round, range check and pack ----
  logic signed [EW-1:0] w_rnd_exp;
  logic [F_BIT-1:0]     w_rnd_frac, w_frac2;
  logic                 w_rnd_carry;
  logic [W-1:0]         w_p;
  flags_t               w_flags;

  float_round_rne #(.E_BIT(E_BIT), .F_BIT(F_BIT)) u_round (
    .i_exp   (r_exp1),
    .i_frac  (r_frac1),
    .i_g     (r_g1),
    .i_s     (r_s1),
    .o_exp   (w_rnd_exp),
    .o_frac  (w_rnd_frac),
    .o_carry (w_rnd_carry)
  );

  // A mantissa carry-out means the significand became 10.000..., so the
  // stored fraction is zero and the exponent has already been bumped.
  assign w_frac2 = w_rnd_carry ? '0 : w_rnd_frac;

  always_comb begin
    w_p     = '0;
    w_flags = '0;
    case (r_cls1)
      CLS_NAN: begin
        w_p         = c_QNAN;
        w_flags.inv = 1'b1;
      end
      CLS_INF:  w_p = {r_sign1, {E_BIT{1'b1}}, {F_BIT{1'b0}}};
      CLS_ZERO: w_p = {r_sign1, {(E_BIT+F_BIT){1'b0}}};
      default: begin
        if (w_rnd_exp >= c_EXP_MAX) begin
          w_p         = {r_sign1, {E_BIT{1'b1}}, {F_BIT{1'b0}}};
          w_flags.ovf = 1'b1;
          w_flags.inx = 1'b1;
        end else if (w_rnd_exp <= c_EXP_ZERO) begin
          w_p         = {r_sign1, {(E_BIT+F_BIT){1'b0}}};
          w_flags.unf = 1'b1;
          w_flags.inx = 1'b1;
        end else begin
          w_p         = {r_sign1, w_rnd_exp[E_BIT-1:0], w_frac2};
          w_flags.inx = r_g1 | r_s1;
        end
      end
    endcase
  end

  logic         r_out_valid;
  logic [W-1:0] r_out_p;
  flags_t       r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0        <= 1'b0;
      r_sign0     <= 1'b0;
      r_cls0      <= CLS_NORM;
      r_exp0      <= '0;
      r_prod0     <= '0;
      r_v1        <= 1'b0;
      r_sign1     <= 1'b0;
      r_cls1      <= CLS_NORM;
      r_exp1      <= '0;
      r_frac1     <= '0;
      r_g1        <= 1'b0;
      r_s1        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_p     <= '0;
      r_flags     <= '0;
    end else if (w_en) begin
      r_v0        <= in_valid;
      r_sign0     <= mul_a[W-1] ^ mul_b[W-1];
      r_cls0      <= w_cls;
      r_exp0      <= w_exp0;
      r_prod0     <= w_prod;
      r_v1        <= r_v0;
      r_sign1     <= r_sign0;
      r_cls1      <= r_cls0;
      r_exp1      <= w_exp1;
      r_frac1     <= w_frac1;
      r_g1        <= w_g1;
      r_s1        <= w_s1;
      r_out_valid <= r_v1;
      r_out_p     <= w_p;
      r_flags     <= w_flags;
    end
  end

  assign out_valid = r_out_valid;
  assign out_p     = r_out_p;
  assign flag_ovf  = r_flags.ovf;
  assign flag_unf  = r_flags.unf;
  assign flag_inv  = r_flags.inv;
  assign flag_inx  = r_flags.inx;

endmodule
`default_nettype wire

// File: tb/tb_float_mul_pipe.sv
`default_nettype none
// Self-checking bench for float_mul_pipe (binary32 configuration) with a
// plain-arithmetic reference model.
module tb_float_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] mul_a, mul_b, out_p;
  logic        flag_ovf, flag_unf, flag_inv, flag_inx;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  assign flags = {flag_ovf, flag_unf, flag_inv, flag_inx};

  always #5 clk = ~clk;

  float_mul_pipe #(.E_BIT(8), .F_BIT(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .flag_inv  (flag_inv),
    .flag_inx  (flag_inx)
  );

  // Reference: exact integer product, rounded to nearest-even by remainder
  // comparison. Returns {product, ovf, unf, inv, inx}.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, sh;
    bit za, zb, ia, ib, na, nb, sign, inexact;
    longint unsigned prod, q, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    sign = a[31] ^ b[31];
    if (na || nb || (ia && zb) || (ib && za)) return {32'h7FC00000, 4'b0010};
    if (ia || ib) return {sign, 8'hFF, 23'h0, 4'b0000};
    if (za || zb) return {sign, 31'h0, 4'b0000};
    prod = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    e  = ea + eb - 127;
    sh = 23;
    if (prod >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end
    q    = prod >> sh;
    rem  = prod - (q << sh);
    half = 64'd1 << (sh - 1);
    inexact = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {sign, 8'hFF, 23'h0, 4'b1001};
    if (e <= 0)   return {sign, 31'h0, 4'b0101};
    return {sign, e[7:0], q[22:0], 3'b000, inexact};
  endfunction

  function automatic logic [31:0] rand_op();
    int          k;
    logic [31:0] r;
    k = $urandom_range(0, 15);
    r = $urandom;
    case (k)
      0:       return {r[31], 31'h0};
      1:       return {r[31], 8'hFF, 23'h0};
      2:       return {r[31], 8'hFF, r[22:0] | 23'h1};
      3:       return {r[31], 8'h00, r[22:0]};
      4:       return r;
      5:       return {r[31], 8'($urandom_range(1, 20)), r[22:0]};
      6:       return {r[31], 8'($urandom_range(230, 254)), r[22:0]};
      default: return {r[31], 8'($urandom_range(100, 154)), r[22:0]};
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mul_a = '0; mul_b = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (out_p !== 32'h0) begin n_fail++; $display("FAIL reset_out_p: got %h expected 00000000", out_p); end
    n_checks++;
    if (flags !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", flags); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] ep, input logic [3:0] ef, input string nm);
    int lat;
    @(negedge clk);
    mul_a = a; mul_b = b; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL %s latency: got %0d expected 3", nm, lat); end
    n_checks++;
    if (out_p !== ep) begin n_fail++; $display("FAIL %s out_p: got %h expected %h", nm, out_p, ep); end
    n_checks++;
    if (flags !== ef) begin n_fail++; $display("FAIL %s flags(ovf,unf,inv,inx): got %b expected %b", nm, flags, ef); end
  endtask

  // Streams n pairs; out_ready is dropped on cycles stall_lo..stall_hi.
  task automatic test_stream(input int n, input int stall_lo, input int stall_hi, input string nm);
    logic [35:0] q[$];
    logic [35:0] e;
    logic [31:0] prev_p;
    bit          took, prev_stall;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0; took = 1'b0; prev_stall = 1'b0; prev_p = '0;
    in_valid = 1'b0;
    while ((sent < n || q.size() > 0) && cyc < 100) begin
      @(negedge clk);
      if (took || !in_valid) begin
        if (sent < n) begin
          in_valid = 1'b1; mul_a = rand_op(); mul_b = rand_op();
        end else in_valid = 1'b0;
      end
      took = 1'b0;
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      #1;
      if (!out_ready && out_valid) begin
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s in_ready_stall c%0d: got %b expected 0", nm, cyc, in_ready); end
        if (prev_stall) begin
          n_checks++;
          if (out_p !== prev_p) begin n_fail++; $display("FAIL %s stall_hold c%0d: got %h expected %h", nm, cyc, out_p, prev_p); end
        end
        prev_p = out_p;
        prev_stall = 1'b1;
      end else prev_stall = 1'b0;
      if (out_ready) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s in_ready c%0d: got %b expected 1", nm, cyc, in_ready); end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_mul(mul_a, mul_b));
        sent++;
        took = 1'b1;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL %s extra_result: got %h expected none", nm, out_p);
        end else begin
          e = q.pop_front();
          got++;
          if ({out_p, flags} !== e) begin
            n_fail++;
            $display("FAIL %s result#%0d: got %h/%b expected %h/%b", nm, got, out_p, flags, e[35:4], e[3:0]);
          end
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (got !== n) begin n_fail++; $display("FAIL %s count: got %0d expected %0d", nm, got, n); end
  endtask

  task automatic test_reset_midstream();
    logic [35:0] e;
    logic [31:0] a, b;
    int          lat, seen;
    bit          hit;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid) hit = 1'b1;
      else begin
        in_valid = 1'b1; mul_a = rand_op(); mul_b = rand_op();
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL midrst_fill: got out_valid 0 expected 1"); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_async_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (out_p !== 32'h0) begin n_fail++; $display("FAIL midrst_async_p: got %h expected 00000000", out_p); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a = rand_op(); b = rand_op();
    e = ref_mul(a, b);
    mul_a = a; mul_b = b; in_valid = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 3", lat); end
    n_checks++;
    if ({out_p, flags} !== e) begin n_fail++; $display("FAIL midrst_result: got %h/%b expected %h/%b", out_p, flags, e[35:4], e[3:0]); end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL midrst_stale: got %0d extra results expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, "mul_1p5x2");
    test_directed(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, "inexact_lsb");
    test_directed(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001, "norm_shift");
    test_directed(32'h7F000000, 32'h40000000, 32'h7F800000, 4'b1001, "overflow");
    test_directed(32'h00800000, 32'h00800000, 32'h00000000, 4'b0101, "underflow");
    test_directed(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b0010, "inf_x_zero");
    test_directed(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, "neg_inf");
    test_stream(24, 1000, 1000, "back_to_back");
    test_stream(8, 4, 9, "backpressure");
    test_stream(40, 10, 17, "random_stall");
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
